// File: rtl/led_count_engine.sv
// LED counter stepped by rising edges of an asynchronous slow clock.
// Supports up, down, bounce and hold modes, plus a level-sampled parallel load.
module led_count_engine #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] leds,
    output logic             step,
    output logic             wrap,
    output logic             dir_out
);

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    localparam logic [WIDTH-1:0] MAX = '1;

    logic s1, s2, s3;
    logic tick, adv;

    logic [WIDTH-1:0] leds_nxt;
    logic             step_nxt;
    logic             wrap_nxt;
    logic             dir_nxt;

    // s1/s2 form the synchroniser; s3 is the delayed copy used for edge detection.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= slow_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;
    assign adv  = tick & run & (mode != MODE_HOLD);

    always_comb begin
        leds_nxt = leds;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;
        dir_nxt  = dir_out;

        // Up and down modes pin the direction every cycle, not only on ticks.
        case (mode)
            MODE_UP:   dir_nxt = 1'b1;
            MODE_DOWN: dir_nxt = 1'b0;
            default:   ;
        endcase

        if (load) begin
            leds_nxt = load_val;
            dir_nxt  = (mode != MODE_DOWN);
        end else if (adv) begin
            step_nxt = 1'b1;
            case (mode)
                MODE_UP: begin
                    leds_nxt = leds + 1'b1;
                    wrap_nxt = (leds == MAX);
                end
                MODE_DOWN: begin
                    leds_nxt = leds - 1'b1;
                    wrap_nxt = (leds == '0);
                end
                MODE_BOUNCE: begin
                    // Reversal steps straight off the endpoint, with no dwell there.
                    if (dir_out) begin
                        leds_nxt = (leds == MAX) ? leds - 1'b1 : leds + 1'b1;
                        if (leds == MAX) begin
                            dir_nxt  = 1'b0;
                            wrap_nxt = 1'b1;
                        end
                    end else begin
                        leds_nxt = (leds == '0) ? leds + 1'b1 : leds - 1'b1;
                        if (leds == '0) begin
                            dir_nxt  = 1'b1;
                            wrap_nxt = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            leds    <= '0;
            step    <= 1'b0;
            wrap    <= 1'b0;
            dir_out <= 1'b1;
        end else begin
            leds    <= leds_nxt;
            step    <= step_nxt;
            wrap    <= wrap_nxt;
            dir_out <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_led_count_engine.sv
// Bench for led_count_engine: a vector table of slow-clock periods, plus hand sequences.
// Each expected step result goes into a queue that a monitor drains.
module tb_led_count_engine;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       slow_clk;
    logic       run;
    logic [1:0] mode;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] leds;
    logic       step;
    logic       wrap;
    logic       dir_out;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [7:0] leds;
        logic       wrap;
        logic       dir;
    } exp_t;

    typedef struct {
        logic [1:0] mode;
        logic       run;
        logic       ld;
        logic [7:0] ld_val;
        logic       rise;
        logic       exp_step;
        logic [7:0] exp_leds;
        logic       exp_wrap;
        logic       exp_dir;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[19];

    led_count_engine #(.WIDTH(8)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .slow_clk (slow_clk),
        .run      (run),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .leds     (leds),
        .step     (step),
        .wrap     (wrap),
        .dir_out  (dir_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic r, input logic ld,
                                input logic [7:0] lv, input logic rs, input logic es,
                                input logic [7:0] el, input logic ew, input logic ed);
        vec_t v;
        v.mode = m; v.run = r; v.ld = ld; v.ld_val = lv; v.rise = rs;
        v.exp_step = es; v.exp_leds = el; v.exp_wrap = ew; v.exp_dir = ed;
        return v;
    endfunction

    // Scoreboard consumer: every step pulse must match the oldest queued expectation.
    always @(negedge clk_in) begin
        if (reset === 1'b0) begin
            if (wrap && !step) chk("wrap_without_step", {31'd0, wrap}, 32'd0);
            if (step) begin
                if (sb.size() == 0) begin
                    chk("unexpected_step", {31'd0, step}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_leds", {24'd0, leds}, {24'd0, e.leds});
                    chk("sb_wrap", {31'd0, wrap}, {31'd0, e.wrap});
                    chk("sb_dir", {31'd0, dir_out}, {31'd0, e.dir});
                end
            end
        end
    end

    task automatic push(input logic [7:0] l, input logic w, input logic d);
        exp_t e;
        e.leds = l; e.wrap = w; e.dir = d;
        sb.push_back(e);
    endtask

    task automatic rise_up(input logic [7:0] exp_l);
        push(exp_l, 1'b0, 1'b1);
        slow_clk = 1'b1;
        repeat (5) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk_in);
        mode = v.mode;
        run  = v.run;
        if (v.ld) begin
            load = 1'b1;
            load_val = v.ld_val;
            @(negedge clk_in);
            load = 1'b0;
        end
        if (v.rise) begin
            if (v.exp_step) push(v.exp_leds, v.exp_wrap, v.exp_dir);
            slow_clk = 1'b1;
            repeat (5) @(negedge clk_in);
            slow_clk = 1'b0;
            repeat (5) @(negedge clk_in);
        end else begin
            repeat (2) @(negedge clk_in);
        end
        chk($sformatf("vec%0d_leds", idx), {24'd0, leds}, {24'd0, v.exp_leds});
        chk($sformatf("vec%0d_dir", idx), {31'd0, dir_out}, {31'd0, v.exp_dir});
    endtask

    initial begin
        //            mode  run ld  ld_val rise step leds  wrap dir
        tbl[0]  = mk(2'b00, 1, 1, 8'hFE, 0, 0, 8'hFE, 0, 1);
        tbl[1]  = mk(2'b00, 1, 0, 8'h00, 1, 1, 8'hFF, 0, 1);
        tbl[2]  = mk(2'b00, 1, 0, 8'h00, 1, 1, 8'h00, 1, 1);
        tbl[3]  = mk(2'b01, 1, 0, 8'h00, 1, 1, 8'hFF, 1, 0);
        tbl[4]  = mk(2'b10, 1, 1, 8'hFD, 0, 0, 8'hFD, 0, 1);
        tbl[5]  = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'hFE, 0, 1);
        tbl[6]  = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'hFF, 0, 1);
        tbl[7]  = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'hFE, 1, 0);
        tbl[8]  = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'hFD, 0, 0);
        tbl[9]  = mk(2'b01, 1, 1, 8'h01, 0, 0, 8'h01, 0, 0);
        tbl[10] = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'h00, 0, 0);
        tbl[11] = mk(2'b10, 1, 0, 8'h00, 1, 1, 8'h01, 1, 1);
        tbl[12] = mk(2'b00, 1, 1, 8'h05, 0, 0, 8'h05, 0, 1);
        tbl[13] = mk(2'b00, 0, 0, 8'h00, 1, 0, 8'h05, 0, 1);
        tbl[14] = mk(2'b00, 0, 0, 8'h00, 1, 0, 8'h05, 0, 1);
        tbl[15] = mk(2'b00, 0, 0, 8'h00, 1, 0, 8'h05, 0, 1);
        tbl[16] = mk(2'b00, 1, 0, 8'h00, 1, 1, 8'h06, 0, 1);
        tbl[17] = mk(2'b11, 1, 0, 8'h00, 1, 0, 8'h06, 0, 1);
        tbl[18] = mk(2'b11, 1, 0, 8'h00, 1, 0, 8'h06, 0, 1);

        reset = 1'b1; slow_clk = 1'b0; run = 1'b1; mode = 2'b00;
        load = 1'b0; load_val = 8'h00;
        repeat (3) @(negedge clk_in);
        chk("rst_leds", {24'd0, leds}, 32'd0);
        chk("rst_step", {31'd0, step}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_dir", {31'd0, dir_out}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk_in);

        // First rise: step must land exactly two edges after slow_clk is sampled.
        push(8'h01, 1'b0, 1'b1);
        slow_clk = 1'b1;
        @(negedge clk_in);
        chk("lat_n", {31'd0, step}, 32'd0);
        @(negedge clk_in);
        chk("lat_n1", {31'd0, step}, 32'd0);
        @(negedge clk_in);
        chk("lat_n2", {31'd0, step}, 32'd1);
        repeat (2) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        for (int i = 2; i <= 12; i++) rise_up(8'(i));
        chk("count12", {24'd0, leds}, 32'd12);

        for (int i = 0; i < 19; i++) apply(tbl[i], i);

        // Load in the very cycle the internal tick is high: tick is dropped.
        @(negedge clk_in);
        mode = 2'b00; run = 1'b1;
        slow_clk = 1'b1;
        @(negedge clk_in);
        @(negedge clk_in);
        load = 1'b1; load_val = 8'h40;
        @(negedge clk_in);
        load = 1'b0;
        chk("ldtick_leds", {24'd0, leds}, 32'h40);
        chk("ldtick_step", {31'd0, step}, 32'd0);
        repeat (3) @(negedge clk_in);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("ldtick_hold", {24'd0, leds}, 32'h40);

        // slow_clk high across reset release produces exactly one tick.
        reset = 1'b1; slow_clk = 1'b1;
        repeat (3) @(negedge clk_in);
        push(8'h01, 1'b0, 1'b1);
        reset = 1'b0;
        repeat (10) @(negedge clk_in);
        chk("rst_hi_leds", {24'd0, leds}, 32'd1);
        slow_clk = 1'b0;
        repeat (5) @(negedge clk_in);
        for (int i = 2; i <= 9; i++) rise_up(8'(i));
        mode = 2'b01;
        @(negedge clk_in);
        chk("pre_rst_leds", {24'd0, leds}, 32'd9);
        chk("pre_rst_dir", {31'd0, dir_out}, 32'd0);
        reset = 1'b1;
        @(negedge clk_in);
        chk("mid_rst_leds", {24'd0, leds}, 32'd0);
        chk("mid_rst_dir", {31'd0, dir_out}, 32'd1);
        chk("mid_rst_step", {31'd0, step}, 32'd0);
        reset = 1'b0; mode = 2'b00;
        repeat (3) @(negedge clk_in);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/led_count_engine.md
Name: led_count_engine

Overview:
- Downstream consumer of the clock divider's slow square-wave output. Runs entirely in the 100 MHz clk_in domain.
- Synchronises the slow clock and detects its rising edges to form one-cycle step ticks.
- Drives an LED counter (board LEDs) in up, down, bounce (ping-pong) or hold mode, with a synchronous parallel load.

Parameters:
- WIDTH, 8, counter/LED width in bits; MAX = 2^WIDTH-1.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- slow_clk  input  1  divided clock from the divider; treated as asynchronous data.
- run  input  1  1 = ticks advance the counter; 0 = ticks ignored.
- mode  input  2  00 up, 01 down, 10 bounce, 11 hold.
- load  input  1  level-sampled; count <= load_val on any cycle where it is high.
- load_val  input  WIDTH  load value.
- leds  output  WIDTH  current count (registered).
- step  output  1  one-cycle pulse, coincident with every count change caused by a tick.
- wrap  output  1  one-cycle pulse on up/down wrap or bounce reversal.
- dir_out  output  1  current direction register, 1 = up.

Behaviour:
- One clock: clk_in. Reset is synchronous, active-high, and takes precedence over all other inputs.
- Reset values: leds=0, step=0, wrap=0, dir_out=1. Sync flops s1, s2, s3 are cleared to 0.
- Synchroniser / edge detect, every cycle: s1<=slow_clk, s2<=s1, s3<=s2. Internal tick = s2 & ~s3.
- Tick latency:
  - slow_clk is sampled high at edge N.
  - tick is high during the cycle following edge N+1.
  - leds, step and wrap update at edge N+2.
- Falling edges of slow_clk produce no tick.
- If slow_clk is high when reset deasserts, exactly one tick is generated. This is intended behaviour.
- Priority per cycle: reset > load > (tick & run & mode!=11).
- Load:
  - leds<=load_val; step=0; wrap=0.
  - dir_out<=1, except in mode 01, where dir_out<=0.
  - A tick arriving in the same cycle as a load is dropped.
- Advancing tick, by mode:
  - Mode 00: leds<=leds+1, mod 2^WIDTH. wrap=1 when MAX->0. dir_out<=1.
  - Mode 01: leds<=leds-1, mod 2^WIDTH. wrap=1 when 0->MAX. dir_out<=0.
  - Mode 10, dir_out=1: at leds=MAX, leds<=MAX-1, dir_out<=0, wrap=1. Otherwise leds+1.
  - Mode 10, dir_out=0: at leds=0, leds<=1, dir_out<=1, wrap=1. Otherwise leds-1.
  - Bounce reversal has no dwell at the endpoint.
  - Mode 11: counter holds and step=0.
- Outside ticks:
  - In modes 00/01, dir_out is forced to 1/0 on every cycle, not only on ticks.
  - In modes 10/11, dir_out retains its value.
- step=1 for exactly one cycle per advancing tick; otherwise 0. wrap is only ever high together with step.
- A mode change takes effect on the next tick. The counter value is never altered by a mode change.
- run=0: ticks are consumed and discarded. There is no backlog, and no catch-up occurs when run returns to 1.
- Reset mid-operation: all state returns to reset values on the next edge. A pending edge in s1/s2 is lost.

Test Plan:
- Reset, mode=00, run=1, slow_clk high 5 cycles / low 5 cycles for 300 cycles -> leds counts 0,1,2,...; one step per slow_clk rise, arriving 2 edges after sample; no step on falls.
- load_val=8'hFE with load pulse, then ticks in mode 00 -> leds FE, FF, 00 with wrap=1 on FF->00; then mode=01 -> 00->FF with wrap=1, dir_out=0.
- load 8'hFD, mode=10 -> leds FE, FF, FE, FD with wrap only on FF->FE; then load 8'h01 -> leds 00, then 01; wrap on the 00->01 reversal, dir_out returns to 1.
- run=0 for 3 slow_clk rises in mode 00 from leds=5 -> leds stays 5, no step; run=1 -> next rise gives 6.
- load asserted in the same cycle as an internal tick with load_val=8'h40 -> leds=40 and step=0 that cycle; mode=11 with ticks -> leds frozen and step=0.
- slow_clk held high, reset pulsed then released -> exactly one step (leds 0->1); reset asserted mid-count at leds=9 -> next cycle leds=0, dir_out=1, step=0.
